// File: rtl/nn_avalon_host.sv
// Avalon-MM master: writes one input vector to the NN peripheral, starts it, polls done, returns the prediction.
// Optional status-poll timeout is enabled by defining NN_HOST_TIMEOUT_EN.
module nn_avalon_host #(
  parameter int         W          = 32,
  parameter int         BIT_WIDTH  = 9,
  parameter int         NUM_INPUTS = 2,
  parameter logic [2:0] IN_BASE    = 3'b000,
  parameter logic [2:0] OUT_ADDR   = 3'b010,
  parameter logic [2:0] CTRL_ADDR  = 3'b011,
  parameter logic [2:0] STAT_ADDR  = 3'b100,
  parameter int         POLL_GAP   = 4,
  parameter int         TIMEOUT    = 1024
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [NUM_INPUTS*BIT_WIDTH-1:0] req_data,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [BIT_WIDTH-1:0]            rsp_data,
  output logic                            rsp_error,
  output logic [2:0]                      address,
  output logic [W-1:0]                    writedata,
  input  logic [W-1:0]                    readdata,
  output logic                            write,
  output logic                            read,
  output logic                            chipselect
);

  localparam int VW    = NUM_INPUTS * BIT_WIDTH;
  localparam int IDX_W = 3;
  localparam int GAP_W = 4;

  typedef enum logic [2:0] {
    IDLE, WR_IN, START_SET, START_CLR, POLL_WAIT, POLL_RD, OUT_RD, RESP
  } state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [GAP_W-1:0]     gap_reg, gap_next;
  logic [VW-1:0]        vec_reg, vec_next;
  logic [BIT_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic                 ready_reg, ready_next;
  logic                 write_reg, write_next;
  logic                 read_reg, read_next;
  logic [2:0]           address_reg, address_next;
  logic [W-1:0]         writedata_reg, writedata_next;
  logic [BIT_WIDTH-1:0] elem [NUM_INPUTS];
  logic                 unused_readdata;

`ifdef NN_HOST_TIMEOUT_EN
  localparam int PC_W = $clog2(TIMEOUT + 1);
  logic [PC_W-1:0] poll_reg, poll_next;
  logic            err_reg, err_next;
`endif

  // Elements come from the vector as it will be after this edge, so the first write can issue right after acceptance.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_elem
      assign elem[gi] = vec_next[gi*BIT_WIDTH +: BIT_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    gap_next      = gap_reg;
    vec_next      = vec_reg;
    rsp_data_next = rsp_data_reg;
`ifdef NN_HOST_TIMEOUT_EN
    poll_next     = poll_reg;
    err_next      = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req_valid && ready_reg) begin
          vec_next   = req_data;
          idx_next   = '0;
          state_next = WR_IN;
`ifdef NN_HOST_TIMEOUT_EN
          err_next   = 1'b0;
`endif
        end
      end
      WR_IN: begin
        if (idx_reg == IDX_W'(NUM_INPUTS - 1)) state_next = START_SET;
        else                                   idx_next   = idx_reg + 1'b1;
      end
      START_SET: state_next = START_CLR;
      START_CLR: begin
        gap_next   = '0;
        state_next = (POLL_GAP == 0) ? POLL_RD : POLL_WAIT;
`ifdef NN_HOST_TIMEOUT_EN
        poll_next  = '0;
`endif
      end
      POLL_WAIT: begin
        if (gap_reg == GAP_W'(POLL_GAP - 1)) state_next = POLL_RD;
        else                                 gap_next   = gap_reg + 1'b1;
      end
      POLL_RD: begin
        if (readdata[0]) begin
          state_next = OUT_RD;
        end else begin
          gap_next   = '0;
          state_next = (POLL_GAP == 0) ? POLL_RD : POLL_WAIT;
`ifdef NN_HOST_TIMEOUT_EN
          poll_next  = poll_reg + 1'b1;
          if (poll_reg == PC_W'(TIMEOUT - 1)) begin
            state_next    = RESP;
            rsp_data_next = '0;
            err_next      = 1'b1;
          end
`endif
        end
      end
      OUT_RD: begin
        rsp_data_next = readdata[BIT_WIDTH-1:0];
        state_next    = RESP;
      end
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus strobes are registered: they describe what the bus does in the state being entered.
  always_comb begin
    write_next     = 1'b0;
    read_next      = 1'b0;
    address_next   = address_reg;
    writedata_next = writedata_reg;
    ready_next     = (state_next == IDLE);
    case (state_next)
      WR_IN: begin
        write_next     = 1'b1;
        address_next   = IN_BASE + idx_next;
        writedata_next = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
          if (idx_next == IDX_W'(i)) writedata_next = W'(elem[i]);
      end
      START_SET: begin
        write_next     = 1'b1;
        address_next   = CTRL_ADDR;
        writedata_next = W'(4'h8);
      end
      START_CLR: begin
        write_next     = 1'b1;
        address_next   = CTRL_ADDR;
        writedata_next = '0;
      end
      POLL_RD: begin
        read_next    = 1'b1;
        address_next = STAT_ADDR;
      end
      OUT_RD: begin
        read_next    = 1'b1;
        address_next = OUT_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      gap_reg       <= '0;
      vec_reg       <= '0;
      rsp_data_reg  <= '0;
      ready_reg     <= 1'b0;
      write_reg     <= 1'b0;
      read_reg      <= 1'b0;
      address_reg   <= '0;
      writedata_reg <= '0;
`ifdef NN_HOST_TIMEOUT_EN
      poll_reg      <= '0;
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      gap_reg       <= gap_next;
      vec_reg       <= vec_next;
      rsp_data_reg  <= rsp_data_next;
      ready_reg     <= ready_next;
      write_reg     <= write_next;
      read_reg      <= read_next;
      address_reg   <= address_next;
      writedata_reg <= writedata_next;
`ifdef NN_HOST_TIMEOUT_EN
      poll_reg      <= poll_next;
      err_reg       <= err_next;
`endif
    end
  end

  assign req_ready  = ready_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_data   = rsp_data_reg;
  assign address    = address_reg;
  assign writedata  = writedata_reg;
  assign write      = write_reg;
  assign read       = read_reg;
  assign chipselect = write_reg | read_reg;
`ifdef NN_HOST_TIMEOUT_EN
  assign rsp_error  = err_reg;
`else
  assign rsp_error  = 1'b0;
`endif

  assign unused_readdata = ^readdata[W-1:BIT_WIDTH];

endmodule

// File: tb/tb_nn_avalon_host.sv
// Directed bench for nn_avalon_host: vector table plus reset, back-pressure and 7-input sequences.
// Build with NN_HOST_TIMEOUT_EN defined to exercise the poll timeout (TIMEOUT=8).
module tb_nn_avalon_host;
  localparam int W = 32, BW = 9, N = 2, GAP = 4, TO = 8, N7 = 7;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset = 1'b1;
  logic            req_valid = 1'b0, req_ready;
  logic [N*BW-1:0] req_data = '0;
  logic            rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [BW-1:0]   rsp_data;
  logic [2:0]      address;
  logic [W-1:0]    writedata, readdata;
  logic            write, read, chipselect;

  logic             req_valid7 = 1'b0, req_ready7;
  logic [N7*BW-1:0] req_data7 = '0;
  logic             rsp_valid7, rsp_ready7 = 1'b0, rsp_error7;
  logic [BW-1:0]    rsp_data7;
  logic [2:0]       address7;
  logic [W-1:0]     writedata7, readdata7;
  logic             write7, read7, chipselect7;

  nn_avalon_host #(.W(W), .BIT_WIDTH(BW), .NUM_INPUTS(N), .POLL_GAP(GAP), .TIMEOUT(TO)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .address(address), .writedata(writedata), .readdata(readdata),
    .write(write), .read(read), .chipselect(chipselect));

  nn_avalon_host #(.W(W), .BIT_WIDTH(BW), .NUM_INPUTS(N7), .POLL_GAP(0), .TIMEOUT(TO)) u_dut7 (
    .clock(clock), .reset(reset), .req_valid(req_valid7), .req_ready(req_ready7), .req_data(req_data7),
    .rsp_valid(rsp_valid7), .rsp_ready(rsp_ready7), .rsp_data(rsp_data7), .rsp_error(rsp_error7),
    .address(address7), .writedata(writedata7), .readdata(readdata7),
    .write(write7), .read(read7), .chipselect(chipselect7));

  typedef struct {
    logic         is_wr;
    logic [2:0]   addr;
    logic [W-1:0] data;
    int           c;
  } ev_t;

  typedef struct {
    logic [N*BW-1:0] d;
    int              fail;
    logic [BW-1:0]   outv;
    logic [BW-1:0]   exp_data;
    logic            exp_err;
    int              exp_lat;
  } vec_t;

  ev_t evq[$];
  ev_t evq7[$];
  int  cyc = 0, stat_seen = 0, done_at = 0;
  int  pass_cnt = 0, tot_cnt = 0;
  int  acc_cyc = 0, ev_base = 0;
  logic [BW-1:0] out_val = '0;

  // Peripheral model: done appears once the configured number of failed polls has been served.
  assign readdata = (read && address == 3'd4) ? {31'h2AAAAAAA, (stat_seen >= done_at)} :
                    (read && address == 3'd2) ? {23'h2ABCDE, out_val} : 32'hFFFF_FFFF;
  assign readdata7 = read7 ? 32'h1 : 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (write || read) begin
      evq.push_back('{write, address, writedata, cyc});
      if (read && address == 3'd4) stat_seen <= stat_seen + 1;
      check("chipselect", {chipselect, write & read}, 2'b10);
    end
    if (write7 || read7) evq7.push_back('{write7, address7, writedata7, cyc});
  end

  function automatic logic [63:0] pk(input ev_t e, input int acc);
    return {e.is_wr, e.addr, e.data[27:0], 32'(e.c - acc)};
  endfunction

  task automatic compare_evs(input string pfx, input ev_t q[$], input int base, input int acc, input ev_t exq[$]);
    check($sformatf("%s_ev_count", pfx), 64'(q.size() - base), 64'(exq.size()));
    for (int i = 0; i < exq.size() && base + i < q.size(); i++)
      check($sformatf("%s_ev%0d", pfx, i), pk(q[base+i], acc), pk(exq[i], acc));
  endtask

  task automatic check_events(input string pfx, input logic [N*BW-1:0] d, input int fail, input logic to);
    ev_t exq[$];
    int  first = acc_cyc + N + 3 + GAP;
    int  nst = to ? TO : fail + 1;
    for (int i = 0; i < N; i++) exq.push_back('{1'b1, 3'(i), W'(d[i*BW +: BW]), acc_cyc + 1 + i});
    exq.push_back('{1'b1, 3'd3, 32'h8, acc_cyc + N + 1});
    exq.push_back('{1'b1, 3'd3, 32'h0, acc_cyc + N + 2});
    for (int j = 0; j < nst; j++) exq.push_back('{1'b0, 3'd4, 32'h0, first + j*(GAP+1)});
    if (!to) exq.push_back('{1'b0, 3'd2, 32'h0, first + fail*(GAP+1) + 1});
    compare_evs(pfx, evq, ev_base, acc_cyc, exq);
  endtask

  task automatic run_req(input logic [N*BW-1:0] d, input int fail, input logic [BW-1:0] outv,
                         input logic hold_valid, output int lat);
    @(negedge clock);
    done_at = stat_seen + fail;
    out_val = outv;
    ev_base = evq.size();
    acc_cyc = cyc;
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_data  = d;
    @(negedge clock);
    if (!hold_valid) req_valid = 1'b0;
    req_data = ~d;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (rsp_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic handshake(input string pfx, input logic [2:0] exp_addr);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({pfx, "_rsp_valid_drop"}, rsp_valid, 1'b0);
    check({pfx, "_req_ready_next"}, req_ready, 1'b1);
    check({pfx, "_addr_hold"}, address, exp_addr);
    check({pfx, "_wdata_hold"}, writedata, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   lat, base, base7, acc7;
    logic [BW-1:0] e7[N7];
    ev_t  ex7[$];

    vt[0] = '{{9'h034, 9'h012}, 0, 9'h055, 9'h055, 1'b0, 11};
    vt[1] = '{{9'h1FF, 9'h000}, 3, 9'h1AB, 9'h1AB, 1'b0, 26};
    vt[2] = '{{9'h155, 9'h0AA}, 1, 9'h000, 9'h000, 1'b0, 16};
    vt[3] = '{{9'h0FE, 9'h101}, 0, 9'h1FF, 9'h1FF, 1'b0, 11};
`ifdef NN_HOST_TIMEOUT_EN
    vt[4] = '{{9'h0C3, 9'h13C}, 9, 9'h07E, 9'h000, 1'b1, 45};
`else
    vt[4] = '{{9'h0C3, 9'h13C}, 9, 9'h07E, 9'h07E, 1'b0, 56};
`endif

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_strobes", {rsp_valid, rsp_error, write, read, chipselect}, 5'b0);
    check("rst_rsp_data", rsp_data, 9'h0);
    check("rst_addr", address, 3'd0);
    check("rst_wdata", writedata, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("req_ready_release", req_ready, 1'b1);

    for (int i = 0; i < 5; i++) begin
      run_req(vt[i].d, vt[i].fail, vt[i].outv, 1'b0, lat);
      $display("txn v%0d: req=%05h polls_failed=%0d latency=%0d rsp_data=%03h rsp_error=%0b",
               i, vt[i].d, vt[i].fail, lat, rsp_data, rsp_error);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
      check($sformatf("v%0d_rsp_data", i), rsp_data, vt[i].exp_data);
      check($sformatf("v%0d_rsp_error", i), rsp_error, vt[i].exp_err);
      check_events($sformatf("v%0d", i), vt[i].d, vt[i].fail, vt[i].exp_err);
      handshake($sformatf("v%0d", i), vt[i].exp_err ? 3'd4 : 3'd2);
    end

    // Back-pressure: result held for 10 cycles while a second request is kept pending
    run_req({9'h0F0, 9'h00F}, 0, 9'h111, 1'b1, lat);
    $display("txn bp: req=%05h latency=%0d rsp_data=%03h", {9'h0F0, 9'h00F}, lat, rsp_data);
    check("bp_latency", 64'(lat), 64'd11);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_hold%0d", k), {rsp_valid, req_ready, rsp_data}, {1'b1, 1'b0, 9'h111});
      @(negedge clock);
    end
    check_events("bp", {9'h0F0, 9'h00F}, 0, 1'b0);
    handshake("bp", 3'd2);
    repeat (3) @(negedge clock);
    check("bp_no_queue", 64'(evq.size() - ev_base), 64'd6);

    // Reset in the middle of the input writes
    @(negedge clock);
    req_valid = 1'b1;
    req_data  = {9'h0AB, 9'h0CD};
    @(negedge clock);
    req_valid = 1'b0;
    check("mid_first_wr", {write, address, writedata}, {1'b1, 3'd0, 32'h0CD});
    #2 reset = 1'b1;
    #1;
    $display("txn reset: asserted during input writes");
    check("mid_async_drop", {write, read, chipselect, req_ready}, 4'b0);
    check("mid_async_bus", {address, writedata}, 35'h0);
    base = evq.size();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("mid_quiet", 64'(evq.size() - base), 64'd0);
    run_req(vt[0].d, 0, 9'h055, 1'b0, lat);
    $display("txn restart: req=%05h latency=%0d rsp_data=%03h", vt[0].d, lat, rsp_data);
    check("restart_latency", 64'(lat), 64'd11);
    check("restart_rsp_data", rsp_data, 9'h055);
    check_events("restart", vt[0].d, 0, 1'b0);
    handshake("restart", 3'd2);

    // Seven inputs, no poll gap
    e7 = '{9'h001, 9'h1FF, 9'h080, 9'h100, 9'h0C3, 9'h03C, 9'h155};
    for (int i = 0; i < N7; i++) req_data7[i*BW +: BW] = e7[i];
    @(negedge clock);
    base7 = evq7.size();
    acc7  = cyc;
    check("n7_req_ready", req_ready7, 1'b1);
    req_valid7 = 1'b1;
    @(negedge clock);
    req_valid7 = 1'b0;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      if (rsp_valid7) begin
        lat = cyc - acc7;
        break;
      end
      @(negedge clock);
    end
    $display("txn n7: req=%016h latency=%0d rsp_data=%03h", req_data7, lat, rsp_data7);
    check("n7_latency", 64'(lat), 64'd12);
    check("n7_rsp", {rsp_error7, rsp_data7}, {1'b0, 9'h001});
    for (int i = 0; i < N7; i++) ex7.push_back('{1'b1, 3'(i), W'(e7[i]), acc7 + 1 + i});
    ex7.push_back('{1'b1, 3'd3, 32'h8, acc7 + 8});
    ex7.push_back('{1'b1, 3'd3, 32'h0, acc7 + 9});
    ex7.push_back('{1'b0, 3'd4, 32'h0, acc7 + 10});
    ex7.push_back('{1'b0, 3'd2, 32'h0, acc7 + 11});
    compare_evs("n7", evq7, base7, acc7, ex7);
    rsp_ready7 = 1'b1;
    @(negedge clock);
    rsp_ready7 = 1'b0;
    check("n7_handshake", {rsp_valid7, req_ready7}, 2'b01);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
